// File: rtl/cpu_core_params.sv
// Shared core-wide types for operand bypassing between pipeline stages.
package cpu_core_params;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       cpu_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // r0 is hard-wired to zero and is never a real write target.
  localparam reg_addr_t ZERO_REG = '0;

  // One in-flight writer as seen from the issue stage.
  typedef struct packed {
    logic      valid;
    logic      we;
    logic      data_ok;
    reg_addr_t addr;
    cpu_data_t data;
  } bypass_src_t;

endpackage

// File: rtl/operand_bypass_resolve.sv
// Resolves one source operand against the EXE/MEM/WB writers.
// Purely combinational. Priority is EXE > MEM > WB > register file.
module operand_bypass_resolve
  import cpu_core_params::*;
(
  input  reg_addr_t   addr_i,
  input  logic        used_i,
  input  cpu_data_t   rf_data_i,
  input  bypass_src_t exe_i,
  input  bypass_src_t mem_i,
  input  bypass_src_t wb_i,
  output cpu_data_t   value_o,
  output logic        hazard_o
);

  logic exe_hit;
  logic mem_hit;
  logic wb_hit;

  assign exe_hit = exe_i.valid && exe_i.we && (exe_i.addr == addr_i);
  assign mem_hit = mem_i.valid && mem_i.we && (mem_i.addr == addr_i);
  assign wb_hit  = wb_i.valid  && wb_i.we  && (wb_i.addr  == addr_i);

  // Pick the youngest matching writer; an unready youngest match stalls
  // even when an older writer has the data, since that data is stale.
  always_comb begin
    value_o  = rf_data_i;
    hazard_o = 1'b0;
    if (addr_i == ZERO_REG) begin
      value_o = '0;
    end else if (exe_hit) begin
      value_o  = exe_i.data;
      hazard_o = used_i && !exe_i.data_ok;
    end else if (mem_hit) begin
      value_o  = mem_i.data;
      hazard_o = used_i && !mem_i.data_ok;
    end else if (wb_hit) begin
      value_o = wb_i.data;
    end
  end

endmodule

// File: rtl/issue_bypass_stage.sv
// Decode-to-execute register with operand forwarding, load-use stall
// detection, valid/ready output handshake and a saturating stall counter.
module issue_bypass_stage
  import cpu_core_params::*;
#(
  parameter type PayloadType     = cpu_core_params::cpu_data_t,
  parameter int  DATA_WIDTH      = 32,
  parameter int  REG_ADDR_WIDTH  = 5,
  parameter int  STALL_CNT_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  PayloadType                 in_payload,
  input  logic [REG_ADDR_WIDTH-1:0]  in_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0]  in_rt_addr,
  input  logic                       in_rs_used,
  input  logic                       in_rt_used,
  input  logic [REG_ADDR_WIDTH-1:0]  in_dest_addr,
  input  logic                       in_dest_we,
  input  logic                       in_is_load,
  input  logic [DATA_WIDTH-1:0]      rf_rs_data,
  input  logic [DATA_WIDTH-1:0]      rf_rt_data,
  input  logic                       exe_valid,
  input  logic                       exe_we,
  input  logic                       exe_data_ok,
  input  logic [REG_ADDR_WIDTH-1:0]  exe_addr,
  input  logic [DATA_WIDTH-1:0]      exe_data,
  input  logic                       mem_valid,
  input  logic                       mem_we,
  input  logic                       mem_data_ok,
  input  logic [REG_ADDR_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0]      mem_data,
  input  logic                       wb_valid,
  input  logic                       wb_we,
  input  logic [REG_ADDR_WIDTH-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output PayloadType                 out_payload,
  output logic [DATA_WIDTH-1:0]      out_rs_value,
  output logic [DATA_WIDTH-1:0]      out_rt_value,
  output logic [REG_ADDR_WIDTH-1:0]  out_dest_addr,
  output logic                       out_dest_we,
  output logic                       out_is_load,
  output logic [STALL_CNT_WIDTH-1:0] stall_count,
  input  logic                       stall_count_clear
);

  bypass_src_t exe_src;
  bypass_src_t mem_src;
  bypass_src_t wb_src;
  cpu_data_t   rs_value;
  cpu_data_t   rt_value;
  logic        rs_hazard;
  logic        rt_hazard;
  logic        hazard;
  logic        fire;

  logic                       out_valid_q,   out_valid_d;
  PayloadType                 payload_q;
  logic [DATA_WIDTH-1:0]      rs_value_q;
  logic [DATA_WIDTH-1:0]      rt_value_q;
  logic [REG_ADDR_WIDTH-1:0]  dest_addr_q;
  logic                       dest_we_q;
  logic                       is_load_q;
  logic [STALL_CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  // Pack the per-stage writer buses into the shared source struct.
  always_comb begin
    exe_src = '{valid: exe_valid, we: exe_we, data_ok: exe_data_ok,
                addr: reg_addr_t'(exe_addr), data: cpu_data_t'(exe_data)};
    mem_src = '{valid: mem_valid, we: mem_we, data_ok: mem_data_ok,
                addr: reg_addr_t'(mem_addr), data: cpu_data_t'(mem_data)};
    wb_src  = '{valid: wb_valid, we: wb_we, data_ok: 1'b1,
                addr: reg_addr_t'(wb_addr), data: cpu_data_t'(wb_data)};
  end

  operand_bypass_resolve u_rs_resolve (
    .addr_i    (reg_addr_t'(in_rs_addr)),
    .used_i    (in_rs_used),
    .rf_data_i (cpu_data_t'(rf_rs_data)),
    .exe_i     (exe_src),
    .mem_i     (mem_src),
    .wb_i      (wb_src),
    .value_o   (rs_value),
    .hazard_o  (rs_hazard)
  );

  operand_bypass_resolve u_rt_resolve (
    .addr_i    (reg_addr_t'(in_rt_addr)),
    .used_i    (in_rt_used),
    .rf_data_i (cpu_data_t'(rf_rt_data)),
    .exe_i     (exe_src),
    .mem_i     (mem_src),
    .wb_i      (wb_src),
    .value_o   (rt_value),
    .hazard_o  (rt_hazard)
  );

  assign hazard   = rs_hazard || rt_hazard;
  assign in_ready = !hazard && !flush && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready;

  // Output valid: flush kills, a new op sets, a consumed op clears.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (fire)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // Stall counter: clear has priority, then saturating increment.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_count_clear) begin
      stall_count_d = '0;
    end else if (in_valid && hazard && !flush &&
                 (stall_count_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // Control state: handshake valid and stall counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Output payload register; loads only on an accepted op so it stays
  // stable while EXE applies backpressure.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      payload_q   <= '0;
      rs_value_q  <= '0;
      rt_value_q  <= '0;
      dest_addr_q <= '0;
      dest_we_q   <= 1'b0;
      is_load_q   <= 1'b0;
    end else if (fire) begin
      payload_q   <= in_payload;
      rs_value_q  <= DATA_WIDTH'(rs_value);
      rt_value_q  <= DATA_WIDTH'(rt_value);
      dest_addr_q <= in_dest_addr;
      dest_we_q   <= in_dest_we;
      is_load_q   <= in_is_load;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_payload   = payload_q;
  assign out_rs_value  = rs_value_q;
  assign out_rt_value  = rt_value_q;
  assign out_dest_addr = dest_addr_q;
  assign out_dest_we   = dest_we_q;
  assign out_is_load   = is_load_q;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_issue_bypass_stage.sv
// Scoreboard bench for issue_bypass_stage (4-bit stall counter instance).
module tb_issue_bypass_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_payload = '0;
  logic [AW-1:0] in_rs_addr = '0, in_rt_addr = '0, in_dest_addr = '0;
  logic          in_rs_used = 1'b0, in_rt_used = 1'b0;
  logic          in_dest_we = 1'b0, in_is_load = 1'b0;
  logic [DW-1:0] rf_rs_data = '0, rf_rt_data = '0;
  logic          exe_valid = 1'b0, exe_we = 1'b0, exe_data_ok = 1'b0;
  logic [AW-1:0] exe_addr = '0;
  logic [DW-1:0] exe_data = '0;
  logic          mem_valid = 1'b0, mem_we = 1'b0, mem_data_ok = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_data = '0;
  logic          wb_valid = 1'b0, wb_we = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_payload;
  logic [DW-1:0] out_rs_value, out_rt_value;
  logic [AW-1:0] out_dest_addr;
  logic          out_dest_we, out_is_load;
  logic [CW-1:0] stall_count;
  logic          stall_count_clear = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]   pl;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [AW-1:0] dest;
    logic          we;
    logic          ld;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  issue_bypass_stage #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STALL_CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_used(in_rs_used), .in_rt_used(in_rt_used),
    .in_dest_addr(in_dest_addr), .in_dest_we(in_dest_we), .in_is_load(in_is_load),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .exe_valid(exe_valid), .exe_we(exe_we), .exe_data_ok(exe_data_ok),
    .exe_addr(exe_addr), .exe_data(exe_data),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_data_ok(mem_data_ok),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_rs_value(out_rs_value), .out_rt_value(out_rt_value),
    .out_dest_addr(out_dest_addr), .out_dest_we(out_dest_we), .out_is_load(out_is_load),
    .stall_count(stall_count), .stall_count_clear(stall_count_clear)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; flush = 0; in_payload = '0;
    in_rs_addr = '0; in_rt_addr = '0; in_rs_used = 0; in_rt_used = 0;
    in_dest_addr = '0; in_dest_we = 0; in_is_load = 0;
    rf_rs_data = '0; rf_rt_data = '0;
    exe_valid = 0; exe_we = 0; exe_data_ok = 0; exe_addr = '0; exe_data = '0;
    mem_valid = 0; mem_we = 0; mem_data_ok = 0; mem_addr = '0; mem_data = '0;
    wb_valid = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
  endtask

  // Drive a decoded op and, when it is expected to fire, queue its result.
  task automatic drive_op(input logic [31:0] pl, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [DW-1:0] exp_rs, input logic [DW-1:0] exp_rt,
                          input logic [AW-1:0] dest, input logic expect_fire);
    exp_t x;
    in_valid = 1; in_payload = pl; in_rs_addr = rs; in_rt_addr = rt;
    in_rs_used = 1; in_rt_used = 1; in_dest_addr = dest; in_dest_we = 1;
    in_is_load = pl[0];
    x.pl = pl; x.rs = exp_rs; x.rt = exp_rt; x.dest = dest; x.we = 1'b1; x.ld = pl[0];
    if (expect_fire) sb.push_back(x);
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (stall_count !== '0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
    checks++; if (out_rs_value !== '0 || out_payload !== '0) begin errors++;
      $display("FAIL reset_data rs=%h pl=%h exp=0", out_rs_value, out_payload); end
    reset_n = 1;
    tick();
  endtask

  task automatic test_exe_priority();
    exe_valid = 1; exe_we = 1; exe_data_ok = 1; exe_addr = 3; exe_data = 32'h11;
    mem_valid = 1; mem_we = 1; mem_data_ok = 1; mem_addr = 3; mem_data = 32'h22;
    rf_rs_data = 32'hAA; rf_rt_data = 32'hBB;
    drive_op(32'h100, 5'd3, 5'd7, 32'h11, 32'hBB, 5'd9, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_ready got=%0b exp=1", in_ready); end
    tick();
    clear_inputs();
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || out_rs_value !== e.rs || out_rt_value !== e.rt || out_payload !== e.pl) begin
      errors++; $display("FAIL prio_out v=%0b rs=%h rt=%h pl=%h exp rs=%h rt=%h pl=%h",
                         out_valid, out_rs_value, out_rt_value, out_payload, e.rs, e.rt, e.pl); end
    checks++; if (out_dest_addr !== e.dest || out_dest_we !== e.we || out_is_load !== e.ld) begin
      errors++; $display("FAIL prio_dest got=%0d/%0b/%0b exp=%0d/%0b/%0b",
                         out_dest_addr, out_dest_we, out_is_load, e.dest, e.we, e.ld); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prio_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_load_use();
    stall_count_clear = 1; tick(); stall_count_clear = 0;
    exe_valid = 1; exe_we = 1; exe_data_ok = 0; exe_addr = 5; exe_data = 32'hDEAD;
    wb_valid = 1; wb_we = 1; wb_addr = 5; wb_data = 32'h33;
    drive_op(32'h201, 5'd0, 5'd5, 32'h0, 32'h44, 5'd6, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_ready got=%0b exp=0", in_ready); end
    tick();
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL ld_cnt1 got=%0d exp=1", stall_count); end
    tick();
    checks++; if (stall_count !== 4'd2 || out_valid !== 1'b0) begin errors++;
      $display("FAIL ld_cnt2 cnt=%0d v=%0b exp cnt=2 v=0", stall_count, out_valid); end
    exe_valid = 0;
    mem_valid = 1; mem_we = 1; mem_data_ok = 1; mem_addr = 5; mem_data = 32'h44;
    drive_op(32'h201, 5'd0, 5'd5, 32'h0, 32'h44, 5'd6, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ld_release got=%0b exp=1", in_ready); end
    tick();
    clear_inputs();
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || out_rt_value !== e.rt || out_rs_value !== e.rs || out_is_load !== e.ld) begin
      errors++; $display("FAIL ld_out v=%0b rt=%h rs=%h ld=%0b exp rt=%h rs=%h ld=%0b",
                         out_valid, out_rt_value, out_rs_value, out_is_load, e.rt, e.rs, e.ld); end
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL ld_cnt_hold got=%0d exp=2", stall_count); end
    tick();
  endtask

  task automatic test_zero_reg();
    exe_valid = 1; exe_we = 1; exe_data_ok = 0; exe_addr = 0; exe_data = 32'hFF;
    rf_rs_data = 32'h55; rf_rt_data = 32'h66;
    drive_op(32'h300, 5'd0, 5'd2, 32'h0, 32'h66, 5'd1, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got=%0b exp=1", in_ready); end
    tick();
    clear_inputs();
    e = sb.pop_front();
    checks++; if (out_rs_value !== e.rs || out_rt_value !== e.rt || out_payload !== e.pl) begin errors++;
      $display("FAIL r0_out rs=%h rt=%h pl=%h exp rs=%h rt=%h pl=%h",
               out_rs_value, out_rt_value, out_payload, e.rs, e.rt, e.pl); end
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL r0_nostall got=%0d exp=2", stall_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    rf_rs_data = 32'h1234; rf_rt_data = 32'h4321;
    drive_op(32'h400, 5'd8, 5'd9, 32'h1234, 32'h4321, 5'd10, 1'b1);
    tick();
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || out_payload !== e.pl || out_rs_value !== e.rs) begin errors++;
      $display("FAIL b2b_a v=%0b pl=%h rs=%h exp pl=%h rs=%h", out_valid, out_payload, out_rs_value, e.pl, e.rs); end
    out_ready = 0;
    rf_rs_data = 32'h5678; rf_rt_data = 32'h8765;
    drive_op(32'h402, 5'd8, 5'd9, 32'h5678, 32'h8765, 5'd11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%0b exp=0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_payload !== e.pl || out_rs_value !== e.rs || out_rt_value !== e.rt) begin
        errors++; $display("FAIL bp_hold[%0d] v=%0b pl=%h rs=%h rt=%h exp pl=%h rs=%h rt=%h",
                           i, out_valid, out_payload, out_rs_value, out_rt_value, e.pl, e.rs, e.rt); end
    end
    out_ready = 1;
    drive_op(32'h402, 5'd8, 5'd9, 32'h5678, 32'h8765, 5'd11, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
    tick();
    clear_inputs();
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || out_payload !== e.pl || out_rs_value !== e.rs || out_dest_addr !== e.dest) begin
      errors++; $display("FAIL b2b_b v=%0b pl=%h rs=%h d=%0d exp pl=%h rs=%h d=%0d",
                         out_valid, out_payload, out_rs_value, out_dest_addr, e.pl, e.rs, e.dest); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush_and_reset();
    out_ready = 0;
    rf_rs_data = 32'h77;
    drive_op(32'h500, 5'd4, 5'd0, 32'h77, 32'h0, 5'd4, 1'b1);
    tick();
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || out_payload !== e.pl) begin errors++;
      $display("FAIL fl_setup v=%0b pl=%h exp pl=%h", out_valid, out_payload, e.pl); end
    out_ready = 1;
    flush = 1;
    drive_op(32'h502, 5'd4, 5'd0, 32'h77, 32'h0, 5'd4, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got=%0b exp=0", in_ready); end
    tick();
    clear_inputs();
    checks++; if (out_valid !== 1'b0 || out_payload !== e.pl) begin errors++;
      $display("FAIL fl_drop v=%0b pl=%h exp v=0 pl=%h", out_valid, out_payload, e.pl); end
    // Hold an entry, then stall behind a load and pulse reset mid-cycle.
    out_ready = 0;
    drive_op(32'h600, 5'd0, 5'd0, 32'h0, 32'h0, 5'd2, 1'b1);
    tick();
    e = sb.pop_front();
    stall_count_clear = 1; tick(); stall_count_clear = 0;
    exe_valid = 1; exe_we = 1; exe_data_ok = 0; exe_addr = 12;
    drive_op(32'h602, 5'd12, 5'd0, 32'h0, 32'h0, 5'd3, 1'b0);
    tick(); tick();
    checks++; if (stall_count !== 4'd2 || out_valid !== 1'b1) begin errors++;
      $display("FAIL rst_pre cnt=%0d v=%0b exp cnt=2 v=1", stall_count, out_valid); end
    #2;
    reset_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || stall_count !== '0 || out_payload !== '0) begin errors++;
      $display("FAIL rst_async v=%0b cnt=%0d pl=%h exp all 0", out_valid, stall_count, out_payload); end
    clear_inputs();
    out_ready = 1;
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_saturation();
    exe_valid = 1; exe_we = 1; exe_data_ok = 0; exe_addr = 7;
    drive_op(32'h700, 5'd7, 5'd0, 32'h0, 32'h0, 5'd8, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    checks++; if (stall_count !== 4'hF) begin errors++; $display("FAIL sat_cnt got=%0d exp=15", stall_count); end
    stall_count_clear = 1;
    tick();
    stall_count_clear = 0;
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL sat_clear got=%0d exp=0", stall_count); end
    tick();
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL sat_resume got=%0d exp=1", stall_count); end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_exe_priority();
    test_load_use();
    test_zero_reg();
    test_back_to_back();
    test_flush_and_reset();
    test_saturation();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
